tx_gearbox_66b32: RTL and testbench
===================================

// Module: tx_gearbox_66b32
// PURPOSE
//  Software 66:32 TX gearbox for GT channels run without the internal gearbox.
//  Sits directly downstream of the tx 64b/66b encode+scramble stage.
//  Consumes 32-bit scrambled halves plus a 2-bit sync header, paced by the 0..32 sequence counter.
//  Emits a continuous 32-bit raw TXDATA word every clock.
//  Per 33-cycle frame: 32 data words + 16 headers (1056 bits) in, 33 words out.
// PARAMETERS
//  SEQ_PAUSE  32  sequence value on which input is ignored (no data, no header)
//  SEQ_W      7   width of sequence_i
//  OUT_REV    0   1: bit-reverse data_o (bit 31 transmitted first); 0: bit 0 first
// PORTS
//  clk_i       in   1   TX user clock, all logic on rising edge
//  rst_n_i     in   1   reset; asynchronous, active-low
//  data_i      in   32  scrambled half-block; even seq = first half, odd seq = second half
//  head_i      in   6   [1:0] sync header, valid on even seq < SEQ_PAUSE; [5:2] ignored
//  sequence_i  in   7   frame counter 0..32, +1 per clock, wraps 32->0
//  data_o      out  32  gearboxed raw word to GT TXDATA
//  valid_o     out  1   data_o carries frame-aligned data
//  seq_err_o   out  1   1-cycle pulse: sequence_i broke the +1 mod 33 pattern
//  fill_o      out  7   debug: bits held in buffer after pop (0..32)
// BEHAVIOUR
//  Reset (async assert, sync release): data_o=0, valid_o=0, seq_err_o=0, fill_o=0.
//    Buffer cleared; FSM=WAIT.
//  Bit order: bit 0 goes on the wire first.
//    Block = head_i[0], head_i[1], then data_i of even seq [0..31], then data_i of odd seq [0..31].
//  FSM:
//    WAIT: ignore input. On sequence_i==0 -> RUN and process that word in the same cycle.
//    RUN: each cycle:
//      push = {data_i,head_i[1:0]} (34b) if seq even and <SEQ_PAUSE;
//             data_i (32b) if odd;
//             nothing if seq==SEQ_PAUSE.
//      Pushed bits are appended above the current fill.
//      Then pop the low 32 bits to data_o and shift the remainder down.
//  Fill arithmetic: fill_next = fill + push_len - 32.
//    Fill is 0 at seq 0, grows +2 per even seq, peaks 64 before pop at seq 30/31.
//    Fill returns to exactly 0 after the pause pop.
//    Buffer = 64 bits plus 2-bit header slot; no underflow is possible in RUN.
//  Latency: 1 clock; data_o/valid_o registered.
//    First valid word is the cycle after seq 0 is sampled, and equals {data0[29:0], head0}.
//  valid_o=1 every cycle in RUN; 0 in WAIT.
//  Sequence check in RUN: expected = (prev==32) ? 0 : prev+1.
//    On mismatch: seq_err_o=1 for one cycle, buffer cleared, valid_o=0, data_o=0, FSM->WAIT.
//    If the bad value is 0, WAIT re-locks on it the same cycle.
//  sequence_i>32 at any time: treated as mismatch in RUN; ignored in WAIT.
//  Fill sanity: a nonzero fill after the pause pop is a defect; the assertion fires.
//  Reset mid-frame: outputs drop immediately; relock on the next seq 0 after release.
//  OUT_REV applies only at the data_o register; fill_o is unaffected.
// STRUCTURE
//  Shared include xgmii_includes.vh holds: SEQ_PAUSE, HDR_W=2, RAW_W=32, and gearbox FSM state codes.
//  Single sub-module gb_shift_buf: 66-bit append/pop buffer with fill count.
//    Inputs: push_data, push_len, clear. Outputs: pop word, fill.
//  Top level holds the FSM, sequence checker and output register.
// TESTING
//  1 Release reset, drive seq 0 with head=2'b10, data=32'hFFFF_FFFF
//    -> next cycle data_o=32'hFFFF_FFFE, valid_o=1, fill_o=2.
//  2 Ten full frames of counting data (word n = n), alternating headers 01/10
//    -> reassembled output bitstream equals reference 66b stream;
//       fill_o==0 after every pause cycle; valid_o continuous.
//  3 Reset released while seq=17
//    -> valid_o=0 for cycles seq 17..32; first valid the cycle after seq 0.
//  4 In RUN, drive seq 5 then 7
//    -> seq_err_o=1 for one cycle, valid_o=0, data_o=0; relock at next seq 0.
//  5 Assert rst_n_i low mid-frame (seq 20), asynchronous to the clock edge
//    -> data_o, valid_o, fill_o all 0 before the next edge; clean relock afterwards.
//  6 OUT_REV=1 with test 1 stimulus -> data_o=32'h7FFF_FFFF.

Source files
------------

// File: rtl/tx_gearbox_66b32_pkg.sv
// Shared constants for the 66:32 TX gearbox: word/header widths, pause slot,
// FSM state codes and the output bit-reversal helper.
package tx_gearbox_66b32_pkg;

  localparam int SEQ_PAUSE_DEF = 32;
  localparam int HDR_W         = 2;
  localparam int RAW_W         = 32;
  localparam int PUSH_W        = HDR_W + RAW_W;
  localparam int BUF_W         = 66;
  localparam int FILL_W        = 7;
  localparam int LEN_W         = 6;

  localparam logic [0:0] ST_WAIT = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  function automatic logic [RAW_W-1:0] bit_rev32(input logic [RAW_W-1:0] w);
    logic [RAW_W-1:0] r;
    for (int i = 0; i < RAW_W; i++) r[i] = w[RAW_W-1-i];
    return r;
  endfunction

endpackage

// File: rtl/tx_gearbox_66b32_gb_shift_buf.sv
// Append/pop bit buffer: new bits land above the held fill, the low 32 bits
// are popped every cycle and the remainder shifts down.
module gb_shift_buf
  import tx_gearbox_66b32_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic [PUSH_W-1:0] push_data_i,
  input  logic [LEN_W-1:0]  push_len_i,
  input  logic              clear_i,
  output logic [RAW_W-1:0]  pop_o,
  output logic [FILL_W-1:0] fill_o
);

  logic [BUF_W-1:0]  buf_q, buf_d;
  logic [BUF_W-1:0]  base, work;
  logic [FILL_W-1:0] fill_q, fill_d, fill_base;
  logic [FILL_W:0]   fill_sum;

  // clear discards held bits before this cycle's push, so a relock can load a fresh word
  always_comb begin
    base      = clear_i ? '0 : buf_q;
    fill_base = clear_i ? '0 : fill_q;
    work      = base | ({{(BUF_W-PUSH_W){1'b0}}, push_data_i} << fill_base);
    fill_sum  = {1'b0, fill_base} + {{(FILL_W+1-LEN_W){1'b0}}, push_len_i};
    pop_o     = work[RAW_W-1:0];
    buf_d     = work >> RAW_W;
    fill_d    = (fill_sum >= (FILL_W+1)'(RAW_W)) ? FILL_W'(fill_sum - (FILL_W+1)'(RAW_W)) : '0;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      buf_q  <= '0;
      fill_q <= '0;
    end else begin
      buf_q  <= buf_d;
      fill_q <= fill_d;
    end
  end

  assign fill_o = fill_q;

endmodule

// File: rtl/tx_gearbox_66b32.sv
// 66:32 TX gearbox: locks on sequence 0, packs header+data into a bit buffer
// and emits one registered 32-bit raw word per clock.
module tx_gearbox_66b32
  import tx_gearbox_66b32_pkg::*;
#(
  parameter int SEQ_PAUSE = SEQ_PAUSE_DEF,
  parameter int SEQ_W     = 7,
  parameter int OUT_REV   = 0
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic [31:0]       data_i,
  input  logic [5:0]        head_i,
  input  logic [SEQ_W-1:0]  sequence_i,
  output logic [31:0]       data_o,
  output logic              valid_o,
  output logic              seq_err_o,
  output logic [FILL_W-1:0] fill_o
);

  logic [0:0]        state_q, state_d;
  logic [SEQ_W-1:0]  prev_q, prev_d, seq_exp;
  logic [RAW_W-1:0]  data_q, data_d, pop;
  logic              valid_q, valid_d, err_q, err_d;
  logic              mismatch, run_word, clear;
  logic [PUSH_W-1:0] push_data;
  logic [LEN_W-1:0]  push_len;
  logic              unused_head;

  assign unused_head = ^head_i[5:2];

  // A bad value of 0 relocks immediately: the buffer restarts and the word is processed
  always_comb begin
    seq_exp   = (prev_q == SEQ_W'(SEQ_PAUSE)) ? '0 : prev_q + SEQ_W'(1);
    mismatch  = (state_q == ST_RUN) && (sequence_i != seq_exp);
    run_word  = ((state_q == ST_RUN) && !mismatch) || (sequence_i == '0);
    clear     = !((state_q == ST_RUN) && !mismatch);
    push_data = '0;
    push_len  = '0;
    if (run_word && (sequence_i != SEQ_W'(SEQ_PAUSE))) begin
      if (!sequence_i[0]) begin
        push_data = {data_i, head_i[1:0]};
        push_len  = LEN_W'(PUSH_W);
      end else begin
        push_data = {{HDR_W{1'b0}}, data_i};
        push_len  = LEN_W'(RAW_W);
      end
    end
    state_d = run_word ? ST_RUN : ST_WAIT;
    prev_d  = run_word ? sequence_i : prev_q;
    valid_d = run_word;
    err_d   = mismatch;
    data_d  = '0;
    if (run_word) data_d = (OUT_REV != 0) ? bit_rev32(pop) : pop;
  end

  gb_shift_buf u_buf (
    .clk_i       (clk_i),
    .rst_n_i     (rst_n_i),
    .push_data_i (push_data),
    .push_len_i  (push_len),
    .clear_i     (clear),
    .pop_o       (pop),
    .fill_o      (fill_o)
  );

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= ST_WAIT;
      prev_q  <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      prev_q  <= prev_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      err_q   <= err_d;
    end
  end

  assign data_o    = data_q;
  assign valid_o   = valid_q;
  assign seq_err_o = err_q;

  // Every frame consumes exactly 33 words' worth of bits, so the pause pop must drain the buffer
  assert property (@(posedge clk_i) disable iff (!rst_n_i)
    (run_word && (sequence_i == SEQ_W'(SEQ_PAUSE))) |=> (fill_o == '0));

endmodule

// File: tb/tb_tx_gearbox_66b32.sv
// Directed bench for tx_gearbox_66b32: vector table, bit-level stream model,
// reset/relock and sequence-error sequences.
module tb_tx_gearbox_66b32;

  logic        clk_i = 1'b0;
  logic        rst_n_i;
  logic [31:0] data_i;
  logic [5:0]  head_i;
  logic [6:0]  sequence_i;
  logic [31:0] data_o, data_rev_o;
  logic        valid_o, valid_rev_o, seq_err_o, seq_err_rev_o;
  logic [6:0]  fill_o, fill_rev_o;

  int compared   = 0;
  int mismatched = 0;
  bit refq[$];

  typedef struct {
    logic [6:0]  seq;
    logic [1:0]  head;
    logic [31:0] data;
    logic [31:0] expData;
    logic        expValid;
    logic [6:0]  expFill;
    logic        expErr;
  } vec_t;

  vec_t vecs[5];

  tx_gearbox_66b32 #(.SEQ_PAUSE(32), .SEQ_W(7), .OUT_REV(0)) dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .data_i(data_i), .head_i(head_i),
    .sequence_i(sequence_i), .data_o(data_o), .valid_o(valid_o),
    .seq_err_o(seq_err_o), .fill_o(fill_o)
  );

  tx_gearbox_66b32 #(.SEQ_PAUSE(32), .SEQ_W(7), .OUT_REV(1)) dutRev (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .data_i(data_i), .head_i(head_i),
    .sequence_i(sequence_i), .data_o(data_rev_o), .valid_o(valid_rev_o),
    .seq_err_o(seq_err_rev_o), .fill_o(fill_rev_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  // Drives one input word, then samples outputs 1 time unit after the edge
  task automatic applyStimulus(input logic [6:0] seq, input logic [1:0] head, input logic [31:0] data);
    sequence_i = seq;
    head_i     = {4'b1011, head};
    data_i     = data;
    @(posedge clk_i);
    #1;
  endtask

  task automatic doReset();
    rst_n_i    = 1'b0;
    sequence_i = 7'd0;
    head_i     = 6'd0;
    data_i     = 32'd0;
    repeat (2) @(posedge clk_i);
    #1;
    checkOutput("rst_data", data_o, 32'd0);
    checkOutput("rst_valid", 32'(valid_o), 32'd0);
    checkOutput("rst_err", 32'(seq_err_o), 32'd0);
    checkOutput("rst_fill", 32'(fill_o), 32'd0);
    checkOutput("rst_rev_data", data_rev_o, 32'd0);
    rst_n_i = 1'b1;
  endtask

  initial begin
    logic [31:0] exp;
    logic [31:0] dt;
    logic [1:0]  hd;
    int          w;
    int          blk;

    vecs[0] = '{7'd0, 2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b1, 7'd2, 1'b0};
    vecs[1] = '{7'd1, 2'b00, 32'h1234_5678, 32'h48D1_59E3, 1'b1, 7'd2, 1'b0};
    vecs[2] = '{7'd2, 2'b01, 32'hA5A5_A5A5, 32'h5A5A_5A54, 1'b1, 7'd4, 1'b0};
    vecs[3] = '{7'd3, 2'b00, 32'h0000_0000, 32'h0000_000A, 1'b1, 7'd4, 1'b0};
    vecs[4] = '{7'd4, 2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFE0, 1'b1, 7'd6, 1'b0};

    // Vector table: first words after lock, including the OUT_REV view of word 0
    doReset();
    for (int i = 0; i < 5; i++) begin
      applyStimulus(vecs[i].seq, vecs[i].head, vecs[i].data);
      checkOutput($sformatf("vec%0d_data", i), data_o, vecs[i].expData);
      checkOutput($sformatf("vec%0d_valid", i), 32'(valid_o), 32'(vecs[i].expValid));
      checkOutput($sformatf("vec%0d_fill", i), 32'(fill_o), 32'(vecs[i].expFill));
      checkOutput($sformatf("vec%0d_err", i), 32'(seq_err_o), 32'(vecs[i].expErr));
      if (i == 0) checkOutput("vec0_rev_data", data_rev_o, 32'h7FFF_FFFF);
    end

    // Ten frames of counting data against a serial bit-stream model
    doReset();
    refq.delete();
    w   = 0;
    blk = 0;
    for (int f = 0; f < 10; f++) begin
      for (int s = 0; s <= 32; s++) begin
        hd = 2'b00;
        dt = 32'hDEAD_BEEF;
        if (s != 32) begin
          dt = 32'(w);
          w++;
          if (s % 2 == 0) begin
            hd = (blk % 2 == 0) ? 2'b01 : 2'b10;
            blk++;
            refq.push_back(hd[0]);
            refq.push_back(hd[1]);
          end
          for (int b = 0; b < 32; b++) refq.push_back(dt[b]);
        end
        applyStimulus(7'(s), hd, dt);
        exp = 32'd0;
        if (refq.size() >= 32) begin
          for (int b = 0; b < 32; b++) exp[b] = refq.pop_front();
        end
        checkOutput($sformatf("frame%0d_seq%0d_data", f, s), data_o, exp);
        checkOutput($sformatf("frame%0d_seq%0d_valid", f, s), 32'(valid_o), 32'd1);
        checkOutput($sformatf("frame%0d_seq%0d_fill", f, s), 32'(fill_o), 32'(refq.size()));
      end
    end

    // Sequence skip 5 -> 7 drops lock until the next seq 0
    for (int s = 0; s <= 5; s++) applyStimulus(7'(s), 2'b01, 32'h1111_1111);
    checkOutput("skip_pre_valid", 32'(valid_o), 32'd1);
    applyStimulus(7'd7, 2'b01, 32'h2222_2222);
    checkOutput("skip_err", 32'(seq_err_o), 32'd1);
    checkOutput("skip_valid", 32'(valid_o), 32'd0);
    checkOutput("skip_data", data_o, 32'd0);
    checkOutput("skip_fill", 32'(fill_o), 32'd0);
    applyStimulus(7'd8, 2'b01, 32'h3333_3333);
    checkOutput("skip_err_pulse", 32'(seq_err_o), 32'd0);
    checkOutput("skip_wait_valid", 32'(valid_o), 32'd0);
    for (int s = 9; s <= 32; s++) begin
      applyStimulus(7'(s), 2'b01, 32'h4444_4444);
      checkOutput($sformatf("skip_wait%0d_valid", s), 32'(valid_o), 32'd0);
    end
    applyStimulus(7'd0, 2'b10, 32'hFFFF_FFFF);
    checkOutput("skip_relock_data", data_o, 32'hFFFF_FFFE);
    checkOutput("skip_relock_valid", 32'(valid_o), 32'd1);
    checkOutput("skip_relock_err", 32'(seq_err_o), 32'd0);

    // Out-of-range sequence value in RUN is an error; in WAIT it is ignored
    applyStimulus(7'd1, 2'b00, 32'h0);
    applyStimulus(7'd40, 2'b00, 32'h0);
    checkOutput("oor_err", 32'(seq_err_o), 32'd1);
    checkOutput("oor_valid", 32'(valid_o), 32'd0);
    applyStimulus(7'd41, 2'b00, 32'h0);
    checkOutput("oor_wait_err", 32'(seq_err_o), 32'd0);

    // Reset released at seq 17: nothing valid until after the next seq 0
    rst_n_i = 1'b0;
    for (int s = 14; s <= 16; s++) applyStimulus(7'(s), 2'b01, 32'h5555_5555);
    rst_n_i = 1'b1;
    for (int s = 17; s <= 32; s++) begin
      applyStimulus(7'(s), 2'b01, 32'h5555_5555);
      checkOutput($sformatf("late_rel%0d_valid", s), 32'(valid_o), 32'd0);
    end
    applyStimulus(7'd0, 2'b10, 32'hFFFF_FFFF);
    checkOutput("late_rel_first_valid", 32'(valid_o), 32'd1);
    checkOutput("late_rel_first_data", data_o, 32'hFFFF_FFFE);

    // Asynchronous reset mid-frame at seq 20, then clean relock
    for (int s = 1; s <= 20; s++) applyStimulus(7'(s), 2'b01, 32'h6666_6666);
    checkOutput("async_pre_valid", 32'(valid_o), 32'd1);
    checkOutput("async_pre_fill", 32'(fill_o), 32'd22);
    #2;
    rst_n_i = 1'b0;
    #1;
    checkOutput("async_data", data_o, 32'd0);
    checkOutput("async_valid", 32'(valid_o), 32'd0);
    checkOutput("async_fill", 32'(fill_o), 32'd0);
    for (int s = 21; s <= 25; s++) applyStimulus(7'(s), 2'b01, 32'h7777_7777);
    rst_n_i = 1'b1;
    for (int s = 26; s <= 32; s++) applyStimulus(7'(s), 2'b01, 32'h7777_7777);
    checkOutput("async_wait_valid", 32'(valid_o), 32'd0);
    applyStimulus(7'd0, 2'b10, 32'hFFFF_FFFF);
    checkOutput("async_relock_data", data_o, 32'hFFFF_FFFE);
    checkOutput("async_relock_rev", data_rev_o, 32'h7FFF_FFFF);
    checkOutput("async_relock_fill", 32'(fill_o), 32'd2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
